// File: rtl/dct_coeff_pingpong.sv
// dct_coeff_pingpong
//
// Reorders one N-point frame of scaled DCT coefficients from the push-only
// RSD stream (arbitrary, typically bit-reversed, index order) into natural
// order 0..N-1. Two N-entry banks alternate: one is filled while the other
// is replayed over a valid/ready interface, so downstream stalls never reach
// the CORDIC pipeline. A sample that arrives while the write bank is still
// full is dropped and the sticky overflow flag is raised.
//
// Ports
//   clk, rst    : single rising-edge clock, synchronous active-high reset
//   in_valid    : a coefficient is presented this cycle (no backpressure)
//   in_sample   : signed coefficient
//   in_index    : destination position of in_sample within its frame
//   in_ready    : status only, the current write bank can accept
//   out_valid   : out_sample / out_index / out_last hold a valid word
//   out_ready   : downstream accepts the current word
//   out_sample  : coefficient in natural order
//   out_index   : position of out_sample, 0..N-1
//   out_last    : high together with index N-1
//   overflow    : sticky, a sample was dropped on a full write bank
module dct_coeff_pingpong #(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int IDX_W  = 3    // log2(N); N must be a power of two >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic        [IDX_W-1:0]  in_index,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  output logic        [IDX_W-1:0]  out_index,
  output logic                     out_last,
  output logic                     overflow
);

  logic signed [DATA_W-1:0] mem_q [2][N];

  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             overflow_q, overflow_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic        [IDX_W-1:0]  out_index_q, out_index_d;
  logic                     out_last_q, out_last_d;

  logic wr_acc, wr_done, rd_load, rd_done;

  assign in_ready = !bank_full_q[wr_bank_q];

  // A write-complete and a read-free in the same cycle always hit different
  // banks: a write needs its bank empty, a free needs its bank full.
  assign wr_acc  = in_valid && !bank_full_q[wr_bank_q];
  assign wr_done = wr_acc && (wr_cnt_q == IDX_W'(N - 1));
  assign rd_load = (!out_valid_q || out_ready) && bank_full_q[rd_bank_q];
  assign rd_done = rd_load && (rd_idx_q == IDX_W'(N - 1));

  always_comb begin
    bank_full_d  = bank_full_q;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    overflow_d   = overflow_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;

    // Write side: frame boundaries come only from the accepted-sample count.
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_done) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_cnt_d               = '0;
      end
    end else if (in_valid) begin
      overflow_d = 1'b1;
    end

    // Read side: registered output stage, refilled whenever it is empty or
    // its word is being taken, so a held out_ready gives one word per cycle.
    if (rd_load) begin
      out_valid_d  = 1'b1;
      out_sample_d = mem_q[rd_bank_q][rd_idx_q];
      out_index_d  = rd_idx_q;
      out_last_d   = (rd_idx_q == IDX_W'(N - 1));
      rd_idx_d     = rd_idx_q + 1'b1;
      if (rd_done) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = ~rd_bank_q;
        rd_idx_d               = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage boundary: control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q  <= 2'b00;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      overflow_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      bank_full_q  <= bank_full_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      overflow_q   <= overflow_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
    end
  end

  // Stage boundary: coefficient storage (contents are don't-care after reset)
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_bank_q][in_index] <= in_sample;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;

endmodule
